tta_memq: RTL and testbench

Queued memory port for the TTA core, parametrised in data width, address width, byte lanes and queue depths. It sits between the core's load/store transport triggers and the external memory controller, and posts writes into a buffer. It keeps up to RDEPTH reads in flight and returns read data in order. It preserves read-after-write ordering by address comparison against the write buffer, and stalls the core only when a triggered request cannot be queued.

---
 rtl/tta_memq.sv | 183 ++++++++++++++++++
 tb/tb_tta_memq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tta_memq.sv
// Queued memory port between the TTA load/store triggers and the memory controller.
// Writes are posted into a buffer; reads are queued, issued in order and their data returned in order.
module tta_memq #(
    parameter int WIDTH   = 32,
    parameter int ADDRESS = 28,
    parameter int BYTES   = 4,
    parameter int WDEPTH  = 4,
    parameter int RDEPTH  = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               c_stall_no,
    input  logic               c_raddr_ti,
    input  logic [ADDRESS-1:0] c_raddr_i,
    input  logic [BYTES-1:0]   c_rbes_ni,
    output logic               c_rvalid_o,
    output logic [WIDTH-1:0]   c_rdata_o,
    output logic [BYTES-1:0]   c_rbes_no,
    input  logic               c_waddr_ti,
    input  logic [ADDRESS-1:0] c_waddr_i,
    input  logic [BYTES-1:0]   c_wbes_ni,
    input  logic [WIDTH-1:0]   c_wdata_i,
    output logic               m_read_o,
    output logic               m_write_o,
    output logic [ADDRESS-1:0] m_addr_o,
    output logic [BYTES-1:0]   m_bes_no,
    output logic [WIDTH-1:0]   m_data_o,
    input  logic               m_busy_i,
    input  logic               m_ready_i,
    input  logic [WIDTH-1:0]   m_data_i
);

    localparam int WPW = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
    localparam int RPW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int WCW = $clog2(WDEPTH + 1);
    localparam int RCW = $clog2(RDEPTH + 1);

    // Write buffer: kept in flops because every entry feeds the hazard comparators.
    logic [ADDRESS-1:0] wb_addr_reg [WDEPTH];
    logic [BYTES-1:0]   wb_bes_reg  [WDEPTH];
    logic [WIDTH-1:0]   wb_data_reg [WDEPTH];
    logic [WDEPTH-1:0]  wb_valid_reg;
    logic [WPW-1:0]     wb_head_reg, wb_tail_reg;
    logic [WCW-1:0]     wb_count_reg, wb_count_next;

    // Read queue (not yet issued) and tag FIFO (issued, awaiting data).
    logic [ADDRESS-1:0] rq_addr_reg [RDEPTH];
    logic [BYTES-1:0]   rq_bes_reg  [RDEPTH];
    logic [RPW-1:0]     rq_head_reg, rq_tail_reg;
    logic [RCW-1:0]     rq_count_reg, rq_count_next;
    logic [BYTES-1:0]   tag_bes_reg [RDEPTH];
    logic [RPW-1:0]     tag_head_reg, tag_tail_reg;
    logic [RCW-1:0]     tag_count_reg, tag_count_next;
    logic [RCW-1:0]     rcount_reg, rcount_next;

    logic               wb_full, rd_full;
    logic               accept_rd, accept_wr;
    logic               issue_rd, issue_wr, ret;
    logic [WDEPTH-1:0]  wb_hit;
    logic               hazard;
    logic [ADDRESS-1:0] rq_head_addr;

    function automatic logic [WPW-1:0] wb_inc(input logic [WPW-1:0] p);
        return (p == WPW'(WDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RPW-1:0] rd_inc(input logic [RPW-1:0] p);
        return (p == RPW'(RDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wb_full    = (wb_count_reg == WCW'(WDEPTH));
    assign rd_full    = (rcount_reg == RCW'(RDEPTH));
    assign c_stall_no = !(c_waddr_ti && wb_full) && !(c_raddr_ti && rd_full);
    assign accept_rd  = c_raddr_ti && c_stall_no;
    assign accept_wr  = c_waddr_ti && c_stall_no;

    assign rq_head_addr = rq_addr_reg[rq_head_reg];

    // Byte enables are deliberately left out: any overlap of word address counts as a hazard.
    generate
        for (genvar gi = 0; gi < WDEPTH; gi++) begin : g_hit
            assign wb_hit[gi] = wb_valid_reg[gi] && (wb_addr_reg[gi] == rq_head_addr);
        end
    endgenerate
    assign hazard = |wb_hit;

    assign issue_rd = !m_busy_i && (rq_count_reg != '0) && !hazard;
    assign issue_wr = !m_busy_i && !issue_rd && (wb_count_reg != '0);
    assign ret      = m_ready_i && (tag_count_reg != '0);

    always_comb begin
        wb_count_next  = wb_count_reg + WCW'(accept_wr) - WCW'(issue_wr);
        rq_count_next  = rq_count_reg + RCW'(accept_rd) - RCW'(issue_rd);
        tag_count_next = tag_count_reg + RCW'(issue_rd) - RCW'(ret);
        rcount_next    = rcount_reg + RCW'(accept_rd) - RCW'(ret);
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers and valid bits.
    always_ff @(posedge clock) begin
        if (accept_wr) begin
            wb_addr_reg[wb_tail_reg] <= c_waddr_i;
            wb_bes_reg[wb_tail_reg]  <= c_wbes_ni;
            wb_data_reg[wb_tail_reg] <= c_wdata_i;
        end
        if (accept_rd) begin
            rq_addr_reg[rq_tail_reg] <= c_raddr_i;
            rq_bes_reg[rq_tail_reg]  <= c_rbes_ni;
        end
        if (issue_rd) begin
            tag_bes_reg[tag_tail_reg] <= rq_bes_reg[rq_head_reg];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wb_valid_reg  <= '0;
            wb_head_reg   <= '0;
            wb_tail_reg   <= '0;
            wb_count_reg  <= '0;
            rq_head_reg   <= '0;
            rq_tail_reg   <= '0;
            rq_count_reg  <= '0;
            tag_head_reg  <= '0;
            tag_tail_reg  <= '0;
            tag_count_reg <= '0;
            rcount_reg    <= '0;
        end else begin
            if (issue_wr) begin
                wb_valid_reg[wb_head_reg] <= 1'b0;
                wb_head_reg               <= wb_inc(wb_head_reg);
            end
            if (accept_wr) begin
                wb_valid_reg[wb_tail_reg] <= 1'b1;
                wb_tail_reg               <= wb_inc(wb_tail_reg);
            end
            if (accept_rd) begin
                rq_tail_reg <= rd_inc(rq_tail_reg);
            end
            if (issue_rd) begin
                rq_head_reg  <= rd_inc(rq_head_reg);
                tag_tail_reg <= rd_inc(tag_tail_reg);
            end
            if (ret) begin
                tag_head_reg <= rd_inc(tag_head_reg);
            end
            wb_count_reg  <= wb_count_next;
            rq_count_reg  <= rq_count_next;
            tag_count_reg <= tag_count_next;
            rcount_reg    <= rcount_next;
        end
    end

    // Registered command and return outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m_read_o   <= 1'b0;
            m_write_o  <= 1'b0;
            m_addr_o   <= '0;
            m_bes_no   <= '1;
            m_data_o   <= '0;
            c_rvalid_o <= 1'b0;
            c_rdata_o  <= '0;
            c_rbes_no  <= '1;
        end else begin
            m_read_o   <= issue_rd;
            m_write_o  <= issue_wr;
            c_rvalid_o <= ret;
            if (issue_rd) begin
                m_addr_o <= rq_head_addr;
                m_bes_no <= rq_bes_reg[rq_head_reg];
            end else if (issue_wr) begin
                m_addr_o <= wb_addr_reg[wb_head_reg];
                m_bes_no <= wb_bes_reg[wb_head_reg];
                m_data_o <= wb_data_reg[wb_head_reg];
            end
            if (ret) begin
                c_rdata_o <= m_data_i;
                c_rbes_no <= tag_bes_reg[tag_head_reg];
            end
        end
    end

endmodule

// File: tb/tb_tta_memq.sv
// Scoreboard bench for tta_memq: directed stimulus pushes expected commands/returns,
// an independent monitor pops and compares whenever the DUT presents an output.
module tb_tta_memq;

    localparam int WIDTH   = 32;
    localparam int ADDRESS = 28;
    localparam int BYTES   = 4;
    localparam int WDEPTH  = 4;
    localparam int RDEPTH  = 2;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               c_stall_no;
    logic               c_raddr_ti;
    logic [ADDRESS-1:0] c_raddr_i;
    logic [BYTES-1:0]   c_rbes_ni;
    logic               c_rvalid_o;
    logic [WIDTH-1:0]   c_rdata_o;
    logic [BYTES-1:0]   c_rbes_no;
    logic               c_waddr_ti;
    logic [ADDRESS-1:0] c_waddr_i;
    logic [BYTES-1:0]   c_wbes_ni;
    logic [WIDTH-1:0]   c_wdata_i;
    logic               m_read_o;
    logic               m_write_o;
    logic [ADDRESS-1:0] m_addr_o;
    logic [BYTES-1:0]   m_bes_no;
    logic [WIDTH-1:0]   m_data_o;
    logic               m_busy_i = 1'b0;
    logic               m_ready_i = 1'b0;
    logic [WIDTH-1:0]   m_data_i = '0;

    tta_memq #(
        .WIDTH(WIDTH), .ADDRESS(ADDRESS), .BYTES(BYTES), .WDEPTH(WDEPTH), .RDEPTH(RDEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .c_stall_no(c_stall_no),
        .c_raddr_ti(c_raddr_ti), .c_raddr_i(c_raddr_i), .c_rbes_ni(c_rbes_ni),
        .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o), .c_rbes_no(c_rbes_no),
        .c_waddr_ti(c_waddr_ti), .c_waddr_i(c_waddr_i), .c_wbes_ni(c_wbes_ni), .c_wdata_i(c_wdata_i),
        .m_read_o(m_read_o), .m_write_o(m_write_o), .m_addr_o(m_addr_o), .m_bes_no(m_bes_no),
        .m_data_o(m_data_o), .m_busy_i(m_busy_i), .m_ready_i(m_ready_i), .m_data_i(m_data_i)
    );

    always #5 clock = ~clock;

    typedef struct { logic wr; logic [ADDRESS-1:0] addr; logic [BYTES-1:0] bes; logic [WIDTH-1:0] data; } cmd_t;
    typedef struct { logic [WIDTH-1:0] data; logic [BYTES-1:0] bes; } ret_t;
    typedef struct { int lat; logic [WIDTH-1:0] data; } resp_t;
    typedef struct { int due; logic [WIDTH-1:0] data; } pend_t;

    cmd_t  exp_cmd[$];
    ret_t  exp_ret[$];
    resp_t resp_q[$];
    pend_t pend_q[$];

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int last_due = 0;
    int ready_count = 0;
    logic busy_mode = 1'b0;
    logic busy_level = 1'b0;
    logic busy_q = 1'b0;

    cmd_t  mon_cmd;
    ret_t  mon_ret;
    resp_t rsp_r;
    pend_t rsp_p;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    task automatic push_cmd(input logic wr, input logic [ADDRESS-1:0] a, input logic [BYTES-1:0] b,
                            input logic [WIDTH-1:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.bes = b; c.data = d;
        exp_cmd.push_back(c);
    endtask

    task automatic push_read(input logic [WIDTH-1:0] d, input logic [BYTES-1:0] b, input int lat);
        ret_t r;
        resp_t s;
        r.data = d; r.bes = b; s.lat = lat; s.data = d;
        exp_ret.push_back(r);
        resp_q.push_back(s);
    endtask

    // Busy driver: either a held level or toggling every cycle.
    always @(negedge clock) begin
        if (busy_mode) m_busy_i = ~m_busy_i;
        else m_busy_i = busy_level;
    end

    always @(posedge clock) busy_q <= m_busy_i;

    // Controller model: answers reads in issue order after a per-read latency.
    always @(negedge clock) begin
        cyc++;
        m_ready_i = 1'b0;
        if (m_read_o && resp_q.size() > 0) begin
            rsp_r = resp_q.pop_front();
            rsp_p.due = (cyc + rsp_r.lat > last_due + 1) ? cyc + rsp_r.lat : last_due + 1;
            rsp_p.data = rsp_r.data;
            last_due = rsp_p.due;
            pend_q.push_back(rsp_p);
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            rsp_p = pend_q.pop_front();
            m_ready_i = 1'b1;
            m_data_i = rsp_p.data;
            ready_count++;
        end
    end

    // Monitor
    always @(negedge clock) begin
        if (m_read_o && m_write_o) begin
            total++;
            $display("FAIL both_cmds: read=1 write=1 want at most one");
        end
        if (m_read_o || m_write_o) begin
            chk("cmd_after_busy", busy_q, 0);
            if (exp_cmd.size() == 0) begin
                total++;
                $display("FAIL unexpected_cmd: write=%0d addr=0x%0h want no command", m_write_o, m_addr_o);
            end else begin
                mon_cmd = exp_cmd.pop_front();
                $display("cmd %s addr=0x%0h bes=%b data=0x%0h", m_write_o ? "W" : "R", m_addr_o, m_bes_no, m_data_o);
                chk("cmd_kind", m_write_o, mon_cmd.wr);
                chk("cmd_addr", m_addr_o, mon_cmd.addr);
                chk("cmd_bes", m_bes_no, mon_cmd.bes);
                if (mon_cmd.wr) chk("cmd_data", m_data_o, mon_cmd.data);
            end
        end
        if (c_rvalid_o) begin
            if (exp_ret.size() == 0) begin
                total++;
                $display("FAIL unexpected_rvalid: data=0x%0h want no return", c_rdata_o);
            end else begin
                mon_ret = exp_ret.pop_front();
                $display("ret data=0x%0h bes=%b", c_rdata_o, c_rbes_no);
                chk("ret_data", c_rdata_o, mon_ret.data);
                chk("ret_bes", c_rbes_no, mon_ret.bes);
            end
        end
    end

    task automatic wait_accept(output int stalls);
        stalls = 0;
        #1;
        while (!c_stall_no && stalls < 300) begin
            stalls++;
            @(negedge clock);
            #1;
        end
        if (!c_stall_no) begin
            total++;
            $display("FAIL accept_timeout: stall=%0d after %0d cycles want 1", c_stall_no, stalls);
        end
        @(posedge clock);
        #1;
        c_raddr_ti = 1'b0;
        c_waddr_ti = 1'b0;
    endtask

    task automatic trig(input logic rd, input logic [ADDRESS-1:0] ra, input logic [BYTES-1:0] rb,
                        input logic wr, input logic [ADDRESS-1:0] wa, input logic [BYTES-1:0] wb,
                        input logic [WIDTH-1:0] wd, output int stalls);
        @(negedge clock);
        c_raddr_ti = rd; c_raddr_i = ra; c_rbes_ni = rb;
        c_waddr_ti = wr; c_waddr_i = wa; c_wbes_ni = wb; c_wdata_i = wd;
        wait_accept(stalls);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_cmd.size() + exp_ret.size() + pend_q.size()) != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", exp_cmd.size() + exp_ret.size() + pend_q.size(), 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic reset_chk();
        chk("rst_m_read", m_read_o, 0);
        chk("rst_m_write", m_write_o, 0);
        chk("rst_rvalid", c_rvalid_o, 0);
        chk("rst_m_addr", m_addr_o, 0);
        chk("rst_m_data", m_data_o, 0);
        chk("rst_rdata", c_rdata_o, 0);
        chk("rst_m_bes", m_bes_no, 4'hF);
        chk("rst_rbes", c_rbes_no, 4'hF);
        chk("rst_stall", c_stall_no, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [BYTES-1:0] wbes_tab [5] = '{4'b0000, 4'b1100, 4'b0011, 4'b1010, 4'b0101};

    initial begin
        int st;
        int r0;
        reset_n = 1'b0;
        c_raddr_ti = 1'b0; c_raddr_i = '0; c_rbes_ni = '1;
        c_waddr_ti = 1'b0; c_waddr_i = '0; c_wbes_ni = '1; c_wdata_i = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_chk();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single read with 4-cycle controller latency
        push_cmd(1'b0, 28'h0000010, 4'b0000, '0);
        push_read(32'h0002A5A5, 4'b0000, 4);
        trig(1'b1, 28'h0000010, 4'b0000, 1'b0, '0, '1, '0, st);
        chk("t1_no_stall", st, 0);
        wait_drain(100);

        // Three reads against RDEPTH=2: third waits for the first return
        push_cmd(1'b0, 28'h100, 4'b1110, '0);
        push_cmd(1'b0, 28'h101, 4'b1101, '0);
        push_cmd(1'b0, 28'h102, 4'b1011, '0);
        push_read(32'h111, 4'b1110, 10);
        push_read(32'h222, 4'b1101, 15);
        push_read(32'h333, 4'b1011, 1);
        r0 = ready_count;
        trig(1'b1, 28'h100, 4'b1110, 1'b0, '0, '1, '0, st);
        chk("t2_r1_stall", st, 0);
        trig(1'b1, 28'h101, 4'b1101, 1'b0, '0, '1, '0, st);
        chk("t2_r2_stall", st, 0);
        trig(1'b1, 28'h102, 4'b1011, 1'b0, '0, '1, '0, st);
        chk("t2_r3_was_stalled", (st > 0), 1);
        chk("t2_returns_before_accept", ready_count - r0, 1);
        wait_drain(200);

        // Write buffer fill with busy held high; fifth write stalls
        busy_level = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 5; i++) push_cmd(1'b1, 28'h30 + 28'(i), wbes_tab[i], 32'h10000000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            trig(1'b0, '0, '1, 1'b1, 28'h30 + 28'(i), wbes_tab[i], 32'h10000000 + 32'(i), st);
            chk("t3_write_no_stall", st, 0);
        end
        @(negedge clock);
        c_waddr_ti = 1'b1; c_waddr_i = 28'h34; c_wbes_ni = wbes_tab[4]; c_wdata_i = 32'h10000004;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_full_stall", c_stall_no, 0);
            @(negedge clock);
        end
        busy_level = 1'b0;
        wait_accept(st);
        chk("t3_fifth_waited", (st > 0), 1);
        wait_drain(100);

        // Read-after-write hazard; an unrelated read bypasses the buffered write
        busy_level = 1'b1;
        repeat (3) @(negedge clock);
        push_cmd(1'b0, 28'h21, 4'b0011, '0);
        push_cmd(1'b1, 28'h20, 4'b0000, 32'h00155);
        push_cmd(1'b0, 28'h20, 4'b1100, '0);
        push_read(32'h2121, 4'b0011, 3);
        push_read(32'h00155, 4'b1100, 3);
        trig(1'b1, 28'h21, 4'b0011, 1'b1, 28'h20, 4'b0000, 32'h00155, st);
        chk("t4_pair_no_stall", st, 0);
        trig(1'b1, 28'h20, 4'b1100, 1'b0, '0, '1, '0, st);
        chk("t4_read_no_stall", st, 0);
        @(negedge clock);
        busy_level = 1'b0;
        wait_drain(100);

        // Continuous writes under toggling busy
        busy_mode = 1'b1;
        for (int i = 0; i < 8; i++) push_cmd(1'b1, 28'h40 + 28'(i), 4'(i), 32'hABC00000 + 32'(i));
        for (int i = 0; i < 8; i++) trig(1'b0, '0, '1, 1'b1, 28'h40 + 28'(i), 4'(i), 32'hABC00000 + 32'(i), st);
        wait_drain(200);
        busy_mode = 1'b0;
        busy_level = 1'b0;
        repeat (2) @(negedge clock);

        // Reset with two reads in flight; their late responses must be ignored
        push_cmd(1'b0, 28'h50, 4'b0110, '0);
        push_cmd(1'b0, 28'h51, 4'b1001, '0);
        resp_q.push_back('{lat: 30, data: 32'hDEAD0001});
        resp_q.push_back('{lat: 30, data: 32'hDEAD0002});
        trig(1'b1, 28'h50, 4'b0110, 1'b0, '0, '1, '0, st);
        trig(1'b1, 28'h51, 4'b1001, 1'b0, '0, '1, '0, st);
        repeat (4) @(negedge clock);
        chk("t6_reads_issued", exp_cmd.size(), 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_chk();
        reset_n = 1'b1;
        @(negedge clock);
        reset_chk();
        wait_drain(100);
        chk("t6_late_ready_seen", pend_q.size() + resp_q.size(), 0);
        push_cmd(1'b0, 28'h60, 4'b0101, '0);
        push_read(32'h6060, 4'b0101, 3);
        trig(1'b1, 28'h60, 4'b0101, 1'b0, '0, '1, '0, st);
        chk("t6_new_read_no_stall", st, 0);
        wait_drain(100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
